// File: rtl/exe_mdu_pkg.sv
// Shared MDU typedefs: opcode and FSM state enums, plus small opcode decoders.
package exe_mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NOP   = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MFHI  = 4'd7,
    MDU_MFLO  = 4'd8
  } MDUOpType;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} mdu_state_e;

  function automatic logic is_mul_op(input MDUOpType op);
    return op inside {MDU_MULT, MDU_MULTU};
  endfunction

  function automatic logic is_div_op(input MDUOpType op);
    return op inside {MDU_DIV, MDU_DIVU};
  endfunction

endpackage

// File: rtl/exe_mdu_if.sv
// EXE-stage <-> MDU signal bundle; master is the pipeline, slave is the MDU.
interface exe_mdu_if
  import exe_mdu_pkg::*;
#(
  parameter int DATA_W = 32
);
  logic              EXE_Flush;
  logic              EXE_Advance;
  MDUOpType          EXE_MDUOp;
  logic              EXE_ExcValid;
  logic [DATA_W-1:0] EXE_BusA;
  logic [DATA_W-1:0] EXE_BusB;
  logic              MDU_Busy;
  logic [DATA_W-1:0] MDU_Result;
  logic [DATA_W-1:0] MDU_HI;
  logic [DATA_W-1:0] MDU_LO;

  modport master (
    output EXE_Flush, EXE_Advance, EXE_MDUOp, EXE_ExcValid, EXE_BusA, EXE_BusB,
    input  MDU_Busy, MDU_Result, MDU_HI, MDU_LO
  );

  modport slave (
    input  EXE_Flush, EXE_Advance, EXE_MDUOp, EXE_ExcValid, EXE_BusA, EXE_BusB,
    output MDU_Busy, MDU_Result, MDU_HI, MDU_LO
  );
endinterface

// File: rtl/exe_mdu_div.sv
// Iterative radix-2 restoring divider on magnitudes, one quotient bit per cycle.
// Result is presented combinationally during the final iteration (done=1).
module mdu_div
  import exe_mdu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sgn,
  input  logic              abort,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);
  localparam int CW = $clog2(DATA_W);

  logic              run, neg_q, neg_r;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] rem, quo, dvs, rem_n, quo_n, a_mag, b_mag;
  logic [DATA_W:0]   shifted, diff;

  assign a_mag = (sgn && dividend[DATA_W-1]) ? -dividend : dividend;
  assign b_mag = (sgn && divisor[DATA_W-1])  ? -divisor  : divisor;

  // quo doubles as the dividend shift register; quotient bits enter at the LSB
  always_comb begin
    shifted = {rem, quo[DATA_W-1]};
    diff    = shifted - {1'b0, dvs};
    rem_n   = diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
    quo_n   = {quo[DATA_W-2:0], ~diff[DATA_W]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run   <= 1'b0;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (abort) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      run   <= 1'b1;
      cnt   <= '0;
      rem   <= '0;
      quo   <= a_mag;
      dvs   <= b_mag;
      // divide-by-zero keeps an all-ones quotient regardless of sign
      neg_q <= sgn && (dividend[DATA_W-1] ^ divisor[DATA_W-1]) && (divisor != '0);
      neg_r <= sgn && dividend[DATA_W-1];
    end else if (run) begin
      rem <= rem_n;
      quo <= quo_n;
      cnt <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

  assign done      = run && (cnt == CW'(DATA_W - 1));
  assign quotient  = neg_q ? -quo_n : quo_n;
  assign remainder = neg_r ? -rem_n : rem_n;
endmodule

// File: rtl/exe_mdu.sv
// EXE-stage multiply/divide unit: owns HI/LO, stalls the pipe while busy and
// commits results only when the instruction leaves EXE unflushed.
module exe_mdu
  import exe_mdu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input logic      clk,
  input logic      rst,
  exe_mdu_if.slave bus
);
  mdu_state_e          state, state_nxt;
  logic [DATA_W-1:0]   hi, lo, tmp_hi, tmp_lo, mul_a, mul_b, div_q, div_r, result;
  logic [2*DATA_W-1:0] mul_ext_a, mul_ext_b, product;
  logic                mul_sgn, op_mul, op_div, issue, busy, commit, mt_ok, div_done;

  assign op_mul = is_mul_op(bus.EXE_MDUOp);
  assign op_div = is_div_op(bus.EXE_MDUOp);
  assign issue  = (state == ST_IDLE) && (op_mul || op_div) && !bus.EXE_ExcValid
                  && !bus.EXE_Flush && !rst;
  assign commit = (state == ST_DONE) && bus.EXE_Advance && !bus.EXE_Flush;
  assign mt_ok  = bus.EXE_Advance && !bus.EXE_Flush && !bus.EXE_ExcValid;

  assign mul_ext_a = {{DATA_W{mul_sgn & mul_a[DATA_W-1]}}, mul_a};
  assign mul_ext_b = {{DATA_W{mul_sgn & mul_b[DATA_W-1]}}, mul_b};
  assign product   = mul_ext_a * mul_ext_b;

  mdu_div #(.DATA_W(DATA_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (issue && op_div),
    .sgn       (bus.EXE_MDUOp == MDU_DIV),
    .abort     (bus.EXE_Flush),
    .dividend  (bus.EXE_BusA),
    .divisor   (bus.EXE_BusB),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      ST_IDLE: if (issue) begin
        state_nxt = op_div ? ST_DIV : ST_MUL;
        busy      = 1'b1;
      end
      ST_MUL: begin
        state_nxt = ST_DONE;
        busy      = 1'b1;
      end
      ST_DIV: begin
        busy = 1'b1;
        if (div_done) state_nxt = ST_DONE;
      end
      ST_DONE: if (bus.EXE_Advance) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    // flush kills everything, including the stall it would otherwise cause
    if (bus.EXE_Flush) begin
      state_nxt = ST_IDLE;
      busy      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      hi      <= '0;
      lo      <= '0;
      tmp_hi  <= '0;
      tmp_lo  <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      mul_sgn <= 1'b0;
    end else begin
      state <= state_nxt;
      if (issue && op_mul) begin
        mul_a   <= bus.EXE_BusA;
        mul_b   <= bus.EXE_BusB;
        mul_sgn <= (bus.EXE_MDUOp == MDU_MULT);
      end
      if (!bus.EXE_Flush && state == ST_MUL) {tmp_hi, tmp_lo} <= product;
      if (!bus.EXE_Flush && state == ST_DIV && div_done) begin
        tmp_hi <= div_r;
        tmp_lo <= div_q;
      end
      if (commit) begin
        hi <= tmp_hi;
        lo <= tmp_lo;
      end
      if (mt_ok && bus.EXE_MDUOp == MDU_MTHI) hi <= bus.EXE_BusA;
      if (mt_ok && bus.EXE_MDUOp == MDU_MTLO) lo <= bus.EXE_BusA;
    end
  end

  always_comb begin
    result = '0;
    if (bus.EXE_MDUOp == MDU_MFHI) result = hi;
    if (bus.EXE_MDUOp == MDU_MFLO) result = lo;
  end

  assign bus.MDU_Busy   = busy;
  assign bus.MDU_Result = result;
  assign bus.MDU_HI     = hi;
  assign bus.MDU_LO     = lo;

  ap_no_adv_while_busy: assert property (@(posedge clk) disable iff (rst)
    !(bus.EXE_Advance && (state == ST_MUL || state == ST_DIV)));
endmodule

// File: doc/exe_mdu.md
Name: exe_mdu

Overview:
- Multiply/divide unit in the EXE stage, directly downstream of the ID/EXE pipeline register.
- Consumes the EXE-stage operands (BusA/BusB) and an MDU opcode.
- Executes MULT/MULTU in 2 cycles and DIV/DIVU in 33 cycles. While an operation is in flight it raises a stall request to the hazard unit.
- Owns the architectural HI/LO registers. It commits to HI/LO only when the instruction leaves EXE unflushed, so exceptions stay precise.

Parameters:
- DATA_W, 32, operand width; the divider runs DATA_W iterations.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- EXE_Flush  in  1  kill the EXE-stage instruction and any in-flight MDU operation
- EXE_Advance  in  1  EXE instruction moves to MEM at this edge (MEM register write enable)
- EXE_MDUOp  in  4  MDUOpType: MDU_NOP, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO, MDU_MFHI, MDU_MFLO
- EXE_ExcValid  in  1  EXE instruction already carries an exception
- EXE_BusA  in  DATA_W  rs operand (dividend / multiplicand / MTxx source)
- EXE_BusB  in  DATA_W  rt operand
- MDU_Busy  out  1  stall request; hazard unit holds EXE/ID/IF while it is 1
- MDU_Result  out  DATA_W  combinational HI for MFHI, LO for MFLO, 0 otherwise
- MDU_HI  out  DATA_W  architectural HI
- MDU_LO  out  DATA_W  architectural LO

Behaviour:
- Reset (async, immediate): state=IDLE, HI=LO=0, temp result regs=0, div counter=0. Consequently MDU_Busy=0 and MDU_Result=0.
- States: IDLE, MUL, DIV, DONE. Flush has priority over every transition below.
- Issue condition, in IDLE: op in {MULT, MULTU, DIV, DIVU}, EXE_ExcValid=0, EXE_Flush=0.
  - MDU_Busy is asserted combinationally in the issue cycle.
  - Operands are latched at the edge.
  - Next state is MUL (multiply ops) or DIV (divide ops, counter=0).
- MUL (1 cycle):
  - MDU_Busy=1.
  - 2*DATA_W product is computed: signed for MULT, unsigned for MULTU.
  - At the edge, the product is stored to temp {hi,lo} and the state goes to DONE.
- DIV (DATA_W cycles):
  - MDU_Busy=1.
  - Radix-2 restoring divider on operand magnitudes, one quotient bit per cycle.
  - When counter=DATA_W-1, at the edge:
    - quotient is sign-fixed (negative if operand signs differ, DIV only);
    - remainder takes the sign of the dividend;
    - results go to temp {hi=rem, lo=quot} and the state goes to DONE.
  - Total busy = 1 issue cycle + DATA_W DIV cycles = 33.
- DONE:
  - MDU_Busy=0, so the pipeline may move.
  - When EXE_Advance=1 and EXE_Flush=0: HI/LO are written from temp at the edge and the state goes to IDLE.
  - When EXE_Advance=0 (downstream stall): stay in DONE, do not reissue, HI/LO unchanged.
- MTHI/MTLO:
  - No state change; MDU_Busy=0.
  - HI (resp. LO) <= EXE_BusA at an edge with EXE_Advance=1, EXE_Flush=0, EXE_ExcValid=0.
- MFHI/MFLO:
  - MDU_Result reads the committed register. No bypass is needed: a commit always happens on the advance edge, before the next instruction reaches EXE.
- EXE_ExcValid=1 at issue: the op is treated as NOP. No busy, no HI/LO write.
- Flush in any state: next state IDLE, temp discarded, no HI/LO write. MDU_Busy drops in the cycle Flush is seen, combinationally forced 0.
- Divide by zero, signed or unsigned: LO=all ones, HI=EXE_BusA, still 33 cycles.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- EXE_Advance=1 while state is MUL or DIV is illegal (protocol assertion); RTL ignores it.
- Back-to-back MDU ops: the second op issues in the cycle after the first commits (state IDLE).

Decomposition:
- MDUOpType enum (4-bit) and the MDU state enum go in the shared CPU_Defines header with the other pipeline typedefs.
- One sub-module, mdu_div: iterative radix-2 divider.
  - Inputs: start, signed flag, dividend, divisor, abort.
  - Outputs: done pulse, quotient, remainder.
- The multiplier stays inline as a single registered product.

Test Plan:
- MULT A=0xFFFFFFFE(-2), B=3, Advance=1 once not busy -> Busy high for 2 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA after the advance edge; a following MFLO returns 0xFFFFFFFA.
- DIVU A=100, B=7 -> Busy high for exactly 33 cycles; then LO=14, HI=2. DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV in flight, EXE_Flush pulsed at DIV cycle 10 -> Busy=0 that cycle; state IDLE next cycle; HI/LO keep prior values (e.g. 0x11111111/0x22222222).
- MULTU reaches DONE with Advance held 0 for 5 cycles -> Busy=0; HI/LO unchanged until Advance=1; exactly one commit, no reissue.
- DIVU A=0x1234, B=0 -> LO=0xFFFFFFFF, HI=0x1234. MTHI 0xDEADBEEF with ExcValid=1 -> HI unchanged; with ExcValid=0 -> HI=0xDEADBEEF.
- Assert rst asynchronously mid-DIV (between clock edges) -> HI=LO=0 and Busy=0 immediately; next MULT 5*6 gives LO=30, HI=0.
